// File: rtl/bcd_xs3_stream_if.sv
// Handshake bundle for the BCD/Excess-3 stream converter: a source-side
// valid/ready word channel and a sink-side valid/ready result channel.
interface bcd_xs3_stream_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [4*DIGITS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic                  out_err;
    logic [DIGITS-1:0]     out_err_mask;
    logic                  busy;

    // Producer/consumer side: drives words in, takes results out.
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_err_mask, busy
    );

    // Converter side.
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, out_err_mask, busy
    );
endinterface

// File: rtl/bcd_xs3_stream.sv
// Multi-digit BCD <-> Excess-3 converter. Accepts a packed word of DIGITS
// nibbles, converts one nibble per clock starting at the least significant
// digit, then holds the result until the sink takes it. Illegal source
// digits come out as 4'hF with their bit set in the error mask.
module bcd_xs3_stream #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_xs3_stream_if.slave  bus
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    word_q;
    logic            mode_q;
    logic [W-1:0]    res_q;
    logic [DIGITS-1:0] mask_q;
    logic [3:0]      cur_digit;
    logic [4:0]      cur_conv;
    logic            last_digit;

    // Single-digit conversion; returns {illegal, converted nibble}.
    // mode 0: BCD -> XS3 (legal 0..9), mode 1: XS3 -> BCD (legal 3..12).
    function automatic logic [4:0] conv_digit(input logic mode, input logic [3:0] d);
        logic       bad;
        logic [3:0] q;
        if (!mode) begin
            bad = (d > 4'd9);
            q   = d + 4'd3;
        end else begin
            bad = (d < 4'd3) || (d > 4'd12);
            q   = d - 4'd3;
        end
        if (bad) begin
            q = 4'hF;
        end
        return {bad, q};
    endfunction

    assign last_digit = (cnt == CW'(DIGITS - 1));

    // Select the digit addressed by the counter and convert it.
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) begin
                cur_digit = word_q[4*i +: 4];
            end
        end
        cur_conv = conv_digit(mode_q, cur_digit);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, walk the digits in CONV, wait for the sink in HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)  state_nxt = CONV;
            CONV: if (last_digit)    state_nxt = HOLD;
            HOLD: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Capture the source word and direction at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            word_q <= bus.in_data;
            mode_q <= bus.in_mode;
        end
    end

    // Digit counter plus result and mask registers, filled one slot per CONV cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            res_q  <= '0;
            mask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt    <= '0;
                        res_q  <= '0;
                        mask_q <= '0;
                    end
                end
                CONV: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CW'(i)) begin
                            res_q[4*i +: 4] <= cur_conv[3:0];
                            mask_q[i]       <= cur_conv[4];
                        end
                    end
                    if (!last_digit) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.out_valid    = (state == HOLD);
    assign bus.out_data     = res_q;
    assign bus.out_err_mask = mask_q;
    assign bus.out_err      = |mask_q;

endmodule

// File: tb/tb_bcd_xs3_stream.sv
// Bench for bcd_xs3_stream: three instances (1, 4 and 8 digits), each
// with a timeline reference model and a per-cycle compare process,
// directed literal cases on the 4-digit instance, and a randomized sweep.
module tb_bcd_xs3_stream;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NI-1:0]        in_valid_v;
    logic [NI-1:0]        in_mode_v;
    logic [NI-1:0][63:0]  in_data_v;
    logic [NI-1:0]        out_ready_v;
    logic [NI-1:0]        in_ready_v;
    logic [NI-1:0]        out_valid_v;
    logic [NI-1:0]        out_err_v;
    logic [NI-1:0]        busy_v;
    logic [NI-1:0][63:0]  out_data_v;
    logic [NI-1:0][15:0]  mask_v;

    function automatic int width_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference conversion from the digit rules, digit by digit with integers.
    task automatic model_word(input int n, input bit mode, input logic [63:0] w,
                              output logic [63:0] d, output logic [15:0] m);
        int  v;
        int  o;
        bit  ok;
        d = '0;
        m = '0;
        for (int i = 0; i < n; i++) begin
            v = int'((w >> (4 * i)) & 64'hF);
            if (!mode) begin
                ok = (v <= 9);
                o  = v + 3;
            end else begin
                ok = (v >= 3) && (v <= 12);
                o  = v - 3;
            end
            if (!ok) begin
                o    = 15;
                m[i] = 1'b1;
            end
            d = d | (64'(o) << (4 * i));
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int N = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        localparam int W = 4 * N;

        bcd_xs3_stream_if #(.DIGITS(N)) bus ();

        bcd_xs3_stream #(.DIGITS(N)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        assign bus.in_valid  = in_valid_v[g];
        assign bus.in_mode   = in_mode_v[g];
        assign bus.in_data   = in_data_v[g][W-1:0];
        assign bus.out_ready = out_ready_v[g];

        assign in_ready_v[g]  = bus.in_ready;
        assign out_valid_v[g] = bus.out_valid;
        assign out_err_v[g]   = bus.out_err;
        assign busy_v[g]      = bus.busy;
        assign out_data_v[g]  = 64'(bus.out_data);
        assign mask_v[g]      = 16'(bus.out_err_mask);

        int          left    = 0;
        bit          m_valid = 1'b0;
        bit          started = 1'b0;
        logic [63:0] m_data  = '0;
        logic [15:0] m_mask  = '0;

        // Timeline model: accept when free, result due N edges later, held until taken.
        always @(posedge clk) begin
            if (!rst_n) begin
                started = 1'b1;
                left    = 0;
                m_valid = 1'b0;
            end else if (m_valid) begin
                if (out_ready_v[g]) m_valid = 1'b0;
            end else if (left > 0) begin
                left = left - 1;
                if (left == 0) m_valid = 1'b1;
            end else if (in_valid_v[g]) begin
                left = N;
                model_word(N, in_mode_v[g], in_data_v[g], m_data, m_mask);
            end
        end

        // Compare DUT against the model on every falling edge.
        always @(negedge clk) begin
            if (started) begin
                check($sformatf("d%0d in_ready", N), 64'(in_ready_v[g]), 64'(!m_valid && left == 0));
                check($sformatf("d%0d busy", N), 64'(busy_v[g]), 64'(m_valid || left != 0));
                check($sformatf("d%0d out_valid", N), 64'(out_valid_v[g]), 64'(m_valid));
                if (m_valid) begin
                    check($sformatf("d%0d out_data", N), out_data_v[g], m_data);
                    check($sformatf("d%0d out_err_mask", N), 64'(mask_v[g]), 64'(m_mask));
                    check($sformatf("d%0d out_err", N), 64'(out_err_v[g]), 64'(m_mask != 0));
                end
            end
        end
    end

    task automatic wait_accept(input int g, output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 60) begin
            ok = (in_ready_v[g] === 1'b1);
            @(negedge clk);
            t++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout d%0d: in_ready %b, required 1", width_of(g), in_ready_v[g]);
        end
    endtask

    task automatic wait_valid(input int g, output int t);
        t = 0;
        while (out_valid_v[g] !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
    endtask

    // One full transaction; hold = cycles of out_ready low once the result is up.
    task automatic xfer(input int g, input bit mode, input logic [63:0] d, input int hold,
                        output logic [63:0] od, output logic [15:0] om, output logic oe);
        bit ok;
        int t;
        int n;
        n = width_of(g);
        @(negedge clk);
        in_valid_v[g]  = 1'b1;
        in_mode_v[g]   = mode;
        in_data_v[g]   = d;
        out_ready_v[g] = (hold == 0);
        wait_accept(g, ok);
        in_valid_v[g] = 1'b0;
        in_mode_v[g]  = 1'($urandom);
        in_data_v[g]  = {$urandom, $urandom};
        od = 'x;
        om = 'x;
        oe = 1'bx;
        if (!ok) return;
        wait_valid(g, t);
        check($sformatf("d%0d latency", n), 64'(t), 64'(n));
        od = out_data_v[g];
        om = mask_v[g];
        oe = out_err_v[g];
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            out_ready_v[g] = 1'b1;
        end
        @(negedge clk);
        check($sformatf("d%0d out_valid after handshake", n), 64'(out_valid_v[g]), 64'd0);
        check($sformatf("d%0d in_ready after handshake", n), 64'(in_ready_v[g]), 64'd1);
        out_ready_v[g] = 1'b0;
    endtask

    // Every digit value in every position, both directions, random surroundings.
    task automatic sweep(input int g);
        int          n;
        logic [63:0] msk;
        logic [63:0] w;
        logic [63:0] od;
        logic [15:0] om;
        logic        oe;
        n   = width_of(g);
        msk = (64'd1 << (4 * n)) - 64'd1;
        for (int pos = 0; pos < n; pos++) begin
            for (int v = 0; v < 16; v++) begin
                for (int m = 0; m < 2; m++) begin
                    w = {$urandom, $urandom} & msk;
                    w[4*pos +: 4] = 4'(v);
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    xfer(g, 1'(m), w, $urandom_range(0, 2), od, om, oe);
                end
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] od;
        logic [63:0] od2;
        logic [15:0] om;
        logic        oe;
        logic        oe2;
        logic [63:0] w;
        bit          ok;
        int          t;

        rst_n       = 1'b0;
        in_valid_v  = '0;
        in_mode_v   = '0;
        in_data_v   = '0;
        out_ready_v = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset d%0d in_ready", width_of(g)), 64'(in_ready_v[g]), 64'd1);
            check($sformatf("reset d%0d out_valid", width_of(g)), 64'(out_valid_v[g]), 64'd0);
            check($sformatf("reset d%0d out_data", width_of(g)), out_data_v[g], 64'd0);
            check($sformatf("reset d%0d out_err_mask", width_of(g)), 64'(mask_v[g]), 64'd0);
            check($sformatf("reset d%0d out_err", width_of(g)), 64'(out_err_v[g]), 64'd0);
            check($sformatf("reset d%0d busy", width_of(g)), 64'(busy_v[g]), 64'd0);
        end
        rst_n = 1'b1;

        // Hand-computed literal cases on the 4-digit instance.
        xfer(1, 1'b0, 64'h1234, 0, od, om, oe);
        check("bcd2xs3 1234 data", od, 64'h4567);
        check("bcd2xs3 1234 err", 64'(oe), 64'd0);
        xfer(1, 1'b1, 64'hC3A5, 0, od, om, oe);
        check("xs32bcd C3A5 data", od, 64'h9072);
        check("xs32bcd C3A5 mask", 64'(om), 64'h0);
        xfer(1, 1'b0, 64'h9A0F, 1, od, om, oe);
        check("bcd2xs3 9A0F data", od, 64'hCF3F);
        check("bcd2xs3 9A0F mask", 64'(om), 64'h5);
        check("bcd2xs3 9A0F err", 64'(oe), 64'd1);
        xfer(1, 1'b1, 64'h2D03, 0, od, om, oe);
        check("xs32bcd 2D03 data", od, 64'hFFF0);
        check("xs32bcd 2D03 mask", 64'(om), 64'hE);
        xfer(0, 1'b0, 64'h7, 0, od, om, oe);
        check("d1 bcd2xs3 7 data", od, 64'hA);
        xfer(2, 1'b1, 64'h3456789C, 0, od, om, oe);
        check("d8 xs32bcd data", od, 64'h01234569);

        // Backpressure with a second word waiting.
        @(negedge clk);
        in_valid_v[1]  = 1'b1;
        in_mode_v[1]   = 1'b0;
        in_data_v[1]   = 64'h0458;
        out_ready_v[1] = 1'b0;
        wait_accept(1, ok);
        in_valid_v[1] = 1'b0;
        wait_valid(1, t);
        check("bp first latency", 64'(t), 64'd4);
        in_valid_v[1] = 1'b1;
        in_mode_v[1]  = 1'b1;
        in_data_v[1]  = 64'h4C63;
        for (int i = 0; i < 5; i++) begin
            check("bp held data", out_data_v[1], 64'h378B);
            check("bp in_ready low", 64'(in_ready_v[1]), 64'd0);
            @(negedge clk);
        end
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        out_ready_v[1] = 1'b0;
        check("bp back to idle", 64'(out_valid_v[1]), 64'd0);
        wait_accept(1, ok);
        in_valid_v[1] = 1'b0;
        wait_valid(1, t);
        check("bp second latency", 64'(t), 64'd4);
        check("bp second data", out_data_v[1], 64'h1930);
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        out_ready_v[1] = 1'b0;

        // Reset while the counter is at 2.
        @(negedge clk);
        in_valid_v[1]  = 1'b1;
        in_mode_v[1]   = 1'b0;
        in_data_v[1]   = 64'h9999;
        out_ready_v[1] = 1'b1;
        wait_accept(1, ok);
        in_valid_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset out_valid", 64'(out_valid_v[1]), 64'd0);
        check("midreset in_ready", 64'(in_ready_v[1]), 64'd1);
        check("midreset out_data", out_data_v[1], 64'd0);
        check("midreset busy", 64'(busy_v[1]), 64'd0);
        rst_n = 1'b1;
        out_ready_v[1] = 1'b0;
        xfer(1, 1'b0, 64'h0909, 0, od, om, oe);
        check("after reset 0909 data", od, 64'h3C3C);

        // BCD -> XS3 -> BCD round trip on legal words.
        for (int k = 0; k < 12; k++) begin
            w = '0;
            for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
            xfer(1, 1'b0, w, $urandom_range(0, 1), od, om, oe);
            xfer(1, 1'b1, od, 0, od2, om, oe2);
            check("roundtrip word", od2, w);
            check("roundtrip err", 64'({oe, oe2}), 64'd0);
        end

        fork
            sweep(0);
            sweep(1);
            sweep(2);
        join

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
